// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states and
// the fault predicates used by both the store and the load paths.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } lsu_state_t;

    // Width is carried in funct3[1:0] for both loads and stores.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3[1:0])
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_illegal(input logic store, input logic [2:0] funct3);
        if (store)
            return funct3 >= 3'b011;
        return (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    endfunction

endpackage

// File: rtl/load_align.sv
// Load-side lane select and sign/zero extension of a memory word.
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    output logic [31:0] data
);

    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    always_comb begin
        byte_s = rdata[{off, 3'b000} +: 8];
        half_s = off[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    data = {{24{byte_s[7]}}, byte_s};
            F3_H:    data = {{16{half_s[15]}}, half_s};
            F3_W:    data = rdata;
            F3_BU:   data = {24'b0, byte_s};
            F3_HU:   data = {16'b0, half_s};
            default: data = 32'b0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the multicycle core FSM and word-addressed data memory:
// one request at a time, store lane replication, load alignment, fault screening.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_addr,
    output logic        mem_wren,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  state;
    logic [3:0]  cnt;
    logic        accept;
    logic        fault;
    logic [1:0]  off;
    logic [3:0]  strb;
    logic [31:0] wdata_rep;
    logic [31:0] load_data;
    logic        store_p0;
    logic [2:0]  funct3_p0;
    logic [1:0]  off_p0;

    assign accept = req_valid && req_ready;
    assign off    = req_addr[1:0];
    assign fault  = is_illegal(req_store, req_funct3) || is_misaligned(req_funct3, off);

    always_comb begin
        strb      = 4'b1111;
        wdata_rep = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                strb      = 4'b0001 << off;
                wdata_rep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                strb      = 4'b0011 << off;
                wdata_rep = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Request capture at the accept edge; the core may change its fields afterwards
    always_ff @(posedge clk) begin
        if (accept) begin
            store_p0  <= req_store;
            funct3_p0 <= req_funct3;
            off_p0    <= off;
        end
    end

    load_align u_load_align (
        .rdata  (mem_rdata),
        .funct3 (funct3_p0),
        .off    (off_p0),
        .data   (load_data)
    );

    // Control FSM; every output is registered so reset clears them asynchronously
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'b0;
            resp_fault <= 1'b0;
            mem_addr   <= 32'b0;
            mem_wren   <= 1'b0;
            mem_wstrb  <= 4'b0;
            mem_wdata  <= 32'b0;
        end else begin
            mem_wren   <= 1'b0;
            mem_wstrb  <= 4'b0;
            mem_wdata  <= 32'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'b0;
            resp_fault <= 1'b0;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        req_ready <= 1'b0;
                        if (fault) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                        end else begin
                            state     <= ACCESS;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_wren  <= req_store;
                            mem_wstrb <= req_store ? strb : 4'b0;
                            mem_wdata <= req_store ? wdata_rep : 32'b0;
                        end
                    end
                end
                ACCESS: begin
                    if (store_p0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                    end else begin
                        state <= WAIT;
                        cnt   <= 4'(MEM_LATENCY - 1);
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= load_data;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
